// File: rtl/hotspot_coeff_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hotspot_coeff_pkg
// Description : Shared constants and FSM state types for the Hotspot2D
//               coefficient register block (register map, AXI responses).
// Revision    : 1.0 - initial release
// ============================================================================
package hotspot_coeff_pkg;

    // Largest coefficient count that still fits the 64-byte register window
    localparam int NUM_COEFFS_MAX = 14;

    // Byte offsets of the register map (word aligned)
    localparam int CTRL_OFS   = 'h00;
    localparam int STATUS_OFS = 'h04;
    localparam int COEFF_BASE = 'h08;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write channel FSM
    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    // Read channel FSM
    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/hotspot_coeff_bank.sv
`default_nettype none
// ============================================================================
// Module      : hotspot_coeff_bank
// Description : Shadow/active coefficient storage. Byte-strobed writes land in
//               the shadow bank; a commit copies shadow to active, deferred
//               while the kernel is busy so an iteration never sees a change.
// Revision    : 1.0 - initial release
// ============================================================================
module hotspot_coeff_bank
    import hotspot_coeff_pkg::*;
#(
    parameter int NUM_COEFFS = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_COEFFS-1:0]    i_wr_sel,
    input  logic [31:0]              i_wr_data,
    input  logic [3:0]               i_wr_strb,
    input  logic                     i_commit,
    input  logic                     i_kern_busy,
    output logic [NUM_COEFFS*32-1:0] o_shadow,
    output logic [NUM_COEFFS*32-1:0] o_active,
    output logic                     o_update,
    output logic                     o_dirty,
    output logic                     o_pending
);

    generate
        if (NUM_COEFFS < 1 || NUM_COEFFS > NUM_COEFFS_MAX) begin : g_bad_num_coeffs
            $error("hotspot_coeff_bank: NUM_COEFFS must be in 1..%0d", NUM_COEFFS_MAX);
        end
    endgenerate

    logic r_commit_req;
    logic r_pending;
    logic r_update;
    logic r_dirty;
    logic w_load;
    logic w_any_wr;

    // A request (fresh or deferred) loads the active bank in the first idle cycle
    assign w_load   = (r_commit_req || r_pending) && !i_kern_busy;
    assign w_any_wr = (|i_wr_sel) && (|i_wr_strb);

    // Commit request register, busy deferral, update pulse and dirty tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_req <= 1'b0;
            r_pending    <= 1'b0;
            r_update     <= 1'b0;
            r_dirty      <= 1'b0;
        end else begin
            r_commit_req <= i_commit;
            // Repeated requests while deferred collapse into this single flag
            r_pending    <= (r_commit_req || r_pending) && i_kern_busy;
            r_update     <= w_load;
            // A shadow write coinciding with the load is not in the copy, so it wins
            if (w_any_wr) begin
                r_dirty <= 1'b1;
            end else if (w_load) begin
                r_dirty <= 1'b0;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_COEFFS; k++) begin : g_coeff
            logic [31:0] r_shadow;
            logic [31:0] r_active;

            // Byte-strobed merge of a bus write into this shadow register
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_shadow <= '0;
                end else if (i_wr_sel[k]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (i_wr_strb[b]) begin
                            r_shadow[8*b +: 8] <= i_wr_data[8*b +: 8];
                        end
                    end
                end
            end

            // Active copy follows the shadow only on a load
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_active <= '0;
                end else if (w_load) begin
                    r_active <= r_shadow;
                end
            end

            assign o_shadow[32*k +: 32] = r_shadow;
            assign o_active[32*k +: 32] = r_active;
        end
    endgenerate

    assign o_update  = r_update;
    assign o_dirty   = r_dirty;
    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/hotspot_coeff_regs.sv
`default_nettype none
// ============================================================================
// Module      : hotspot_coeff_regs
// Description : AXI4-Lite responder for the Hotspot2D solver coefficients.
//               Holds the write/read channel FSMs and the address decode; the
//               coefficient storage lives in hotspot_coeff_bank.
// Revision    : 1.0 - initial release
// ============================================================================
module hotspot_coeff_regs
    import hotspot_coeff_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_COEFFS         = 6
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic                            kern_busy,
    output logic [NUM_COEFFS*32-1:0]        coeff_o,
    output logic                            coeff_update
);

    generate
        if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
            $error("hotspot_coeff_regs: only a 32-bit data bus is supported");
        end
    endgenerate

    wr_state_t r_wstate;
    wr_state_t w_wstate_nxt;
    rd_state_t r_rstate;
    rd_state_t w_rstate_nxt;

    logic                     w_wr_accept;
    logic                     w_rd_accept;
    logic [NUM_COEFFS-1:0]    w_wr_sel;
    logic                     w_commit;
    logic [1:0]               w_wr_resp;
    logic [31:0]              w_rd_data;
    logic [1:0]               w_rd_resp;
    int                       w_wr_baddr;
    int                       w_rd_baddr;

    logic [1:0]               r_bresp;
    logic [31:0]              r_rdata;
    logic [1:0]               r_rresp;

    logic [NUM_COEFFS*32-1:0] w_shadow;
    logic                     w_dirty;
    logic                     w_pending;

    logic                     w_unused;

    // Protection bits and byte lanes within a word carry no meaning here
    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign w_wr_baddr = int'({S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2], 2'b00});
    assign w_rd_baddr = int'({S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2], 2'b00});

    // Write FSM next state; AW and W are only taken together, never split
    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wr_accept  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_ARESET) begin
                    w_wr_accept  = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Write FSM state register
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    // Write address decode: enables are gated by the handshake so misses change nothing
    always_comb begin
        w_wr_sel  = '0;
        w_commit  = 1'b0;
        w_wr_resp = RESP_SLVERR;
        if (w_wr_baddr == CTRL_OFS) begin
            w_wr_resp = RESP_OKAY;
            w_commit  = w_wr_accept && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
        end
        for (int k = 0; k < NUM_COEFFS; k++) begin
            if (w_wr_baddr == COEFF_BASE + 4*k) begin
                w_wr_resp   = RESP_OKAY;
                w_wr_sel[k] = w_wr_accept;
            end
        end
    end

    // Capture the write response at the handshake; held until BREADY
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_bresp <= RESP_OKAY;
        end else if (w_wr_accept) begin
            r_bresp <= w_wr_resp;
        end
    end

    // Read FSM next state
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rd_accept  = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (S_AXI_ARVALID && !S_AXI_ARESET) begin
                    w_rd_accept  = 1'b1;
                    w_rstate_nxt = R_DATA;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read FSM state register
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    // Read mux over current register contents (pre-write value on a same-cycle write)
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_SLVERR;
        if (w_rd_baddr == CTRL_OFS) begin
            w_rd_resp = RESP_OKAY;
        end else if (w_rd_baddr == STATUS_OFS) begin
            w_rd_data = {30'd0, w_pending, w_dirty};
            w_rd_resp = RESP_OKAY;
        end
        for (int k = 0; k < NUM_COEFFS; k++) begin
            if (w_rd_baddr == COEFF_BASE + 4*k) begin
                w_rd_data = w_shadow[32*k +: 32];
                w_rd_resp = RESP_OKAY;
            end
        end
    end

    // Register read data at the handshake; held stable until RREADY
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
        end else if (w_rd_accept) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
        end
    end

    assign S_AXI_AWREADY = w_wr_accept;
    assign S_AXI_WREADY  = w_wr_accept;
    assign S_AXI_BVALID  = (r_wstate == W_RESP);
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = (r_rstate == R_IDLE) && !S_AXI_ARESET;
    assign S_AXI_RVALID  = (r_rstate == R_DATA);
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;

    hotspot_coeff_bank #(
        .NUM_COEFFS (NUM_COEFFS)
    ) u_bank (
        .clk         (S_AXI_ACLK),
        .rst         (S_AXI_ARESET),
        .i_wr_sel    (w_wr_sel),
        .i_wr_data   (S_AXI_WDATA[31:0]),
        .i_wr_strb   (S_AXI_WSTRB[3:0]),
        .i_commit    (w_commit),
        .i_kern_busy (kern_busy),
        .o_shadow    (w_shadow),
        .o_active    (coeff_o),
        .o_update    (coeff_update),
        .o_dirty     (w_dirty),
        .o_pending   (w_pending)
    );

endmodule
`default_nettype wire

// File: tb/tb_hotspot_coeff_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_hotspot_coeff_regs
// Description : Directed self-checking bench for hotspot_coeff_regs. Expected
//               B and R responses are queued when a transfer is issued and
//               compared when the response channel presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hotspot_coeff_regs;
    import hotspot_coeff_pkg::*;

    localparam int NC = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [5:0]    awaddr = '0;
    logic [2:0]    awprot = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [31:0]   wdata = '0;
    logic [3:0]    wstrb = '0;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [5:0]    araddr = '0;
    logic [2:0]    arprot = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b0;
    logic          kern_busy = 1'b0;
    logic [NC*32-1:0] coeff_o;
    logic          coeff_update;

    int n_cmp = 0;
    int n_fail = 0;
    int pulse_cnt = 0;

    logic [1:0]  bresp_q[$];
    logic [33:0] rd_q[$];

    hotspot_coeff_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (6),
        .NUM_COEFFS         (NC)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .kern_busy     (kern_busy),
        .coeff_o       (coeff_o),
        .coeff_update  (coeff_update)
    );

    always #5 clk = ~clk;

    // Count coefficient update pulses
    always @(posedge clk) begin
        if (coeff_update === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present AW+W, wait (bounded) for the handshake, end one cycle after it
    task automatic wr_start(input logic [5:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] exp_resp);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        bresp_q.push_back(exp_resp);
        #1;
        n = 0;
        while (!(awready && wready) && n < 16) begin
            @(posedge clk); #2; n++;
        end
        chk("wr_handshake", {63'd0, awready && wready}, 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic b_finish();
        logic [1:0] e;
        chk("bvalid", {63'd0, bvalid}, 64'd1);
        e = bresp_q.pop_front();
        chk("bresp", {62'd0, bresp}, {62'd0, e});
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] exp_resp);
        wr_start(a, d, s, exp_resp);
        b_finish();
    endtask

    task automatic rd_start(input logic [5:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
        int n;
        araddr = a; arvalid = 1'b1;
        rd_q.push_back({exp_r, exp_d});
        #1;
        n = 0;
        while (!arready && n < 16) begin
            @(posedge clk); #2; n++;
        end
        chk("rd_handshake", {63'd0, arready}, 64'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic r_finish(input string tag);
        logic [33:0] e;
        chk({tag, " rvalid"}, {63'd0, rvalid}, 64'd1);
        e = rd_q.pop_front();
        chk({tag, " rdata"}, {32'd0, rdata}, {32'd0, e[31:0]});
        chk({tag, " rresp"}, {62'd0, rresp}, {62'd0, e[33:32]});
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic axi_read(input string tag, input logic [5:0] a,
                            input logic [31:0] exp_d, input logic [1:0] exp_r);
        rd_start(a, exp_d, exp_r);
        r_finish(tag);
    endtask

    initial begin
        // ---- Reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst arready", {63'd0, arready}, 64'd0);
        chk("rst awready", {63'd0, awready}, 64'd0);
        chk("rst bvalid", {63'd0, bvalid}, 64'd0);
        chk("rst rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst bresp", {62'd0, bresp}, 64'd0);
        chk("rst rresp", {62'd0, rresp}, 64'd0);
        chk("rst rdata", {32'd0, rdata}, 64'd0);
        chk("rst coeff_update", {63'd0, coeff_update}, 64'd0);
        for (int k = 0; k < NC; k++) chk("rst coeff_o", {32'd0, coeff_o[32*k +: 32]}, 64'd0);
        rst = 1'b0;
        tick();
        axi_read("status after reset", 6'h04, 32'h0, RESP_OKAY);

        // ---- Shadow write does not reach the active bank ----
        axi_write(6'h08, 32'h3F80_0000, 4'hF, RESP_OKAY);
        axi_read("coeff0 shadow", 6'h08, 32'h3F80_0000, RESP_OKAY);
        chk("coeff0 active before commit", {32'd0, coeff_o[31:0]}, 64'd0);
        axi_read("status dirty", 6'h04, 32'h1, RESP_OKAY);

        // ---- Commit with kernel idle: pulse two cycles after handshake ----
        axi_write(6'h00, 32'h1, 4'hF, RESP_OKAY);
        chk("commit pulse", {63'd0, coeff_update}, 64'd1);
        chk("coeff0 active", {32'd0, coeff_o[31:0]}, 64'h3F80_0000);
        tick();
        chk("commit pulse width", {63'd0, coeff_update}, 64'd0);
        chk("pulse count 1", pulse_cnt, 64'd1);
        axi_read("status clean", 6'h04, 32'h0, RESP_OKAY);

        // ---- Deferred commits while busy merge into one update ----
        kern_busy = 1'b1;
        axi_write(6'h00, 32'h1, 4'hF, RESP_OKAY);
        axi_write(6'h0C, 32'h4000_0000, 4'hF, RESP_OKAY);
        axi_write(6'h00, 32'h1, 4'hF, RESP_OKAY);
        axi_read("status pending", 6'h04, 32'h3, RESP_OKAY);
        chk("no pulse while busy", pulse_cnt, 64'd1);
        chk("coeff1 held while busy", {32'd0, coeff_o[63:32]}, 64'd0);
        kern_busy = 1'b0;
        tick();
        chk("deferred pulse", {63'd0, coeff_update}, 64'd1);
        chk("coeff1 active", {32'd0, coeff_o[63:32]}, 64'h4000_0000);
        tick();
        tick();
        chk("pulse count 2", pulse_cnt, 64'd2);
        axi_read("status after deferred", 6'h04, 32'h0, RESP_OKAY);

        // ---- Byte strobes merge into an existing value ----
        axi_write(6'h10, 32'h1122_3344, 4'hF, RESP_OKAY);
        axi_write(6'h10, 32'hAABB_CCDD, 4'b0101, RESP_OKAY);
        axi_read("strobe merge", 6'h10, 32'h11BB_33DD, RESP_OKAY);

        // ---- Decode errors leave state alone ----
        axi_write(6'h20, 32'hDEAD_BEEF, 4'hF, RESP_SLVERR);
        axi_write(6'h04, 32'h3, 4'hF, RESP_SLVERR);
        axi_read("read out of range", 6'h20, 32'h0, RESP_SLVERR);
        axi_read("read top of window", 6'h3C, 32'h0, RESP_SLVERR);
        axi_read("status unchanged", 6'h04, 32'h1, RESP_OKAY);
        axi_read("ctrl reads zero", 6'h00, 32'h0, RESP_OKAY);
        axi_read("low addr bits ignored", 6'h0B, 32'h3F80_0000, RESP_OKAY);
        chk("active unchanged", coeff_o[63:0], 64'h4000_0000_3F80_0000);
        chk("pulse count after errors", pulse_cnt, 64'd2);

        // ---- B stall: stable response, no second acceptance ----
        wr_start(6'h14, 32'h1234_5678, 4'hF, RESP_OKAY);
        awaddr = 6'h18; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bstall bvalid", {63'd0, bvalid}, 64'd1);
            chk("bstall bresp", {62'd0, bresp}, {62'd0, RESP_OKAY});
            chk("bstall no accept", {63'd0, awready || wready}, 64'd0);
            tick();
        end
        b_finish();
        bresp_q.push_back(RESP_OKAY);
        chk("accept after B", {63'd0, awready && wready}, 64'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        b_finish();

        // ---- R stall: stable data, no new read accepted ----
        rd_start(6'h14, 32'h1234_5678, RESP_OKAY);
        for (int i = 0; i < 5; i++) begin
            chk("rstall rvalid", {63'd0, rvalid}, 64'd1);
            chk("rstall rdata", {32'd0, rdata}, 64'h1234_5678);
            chk("rstall arready", {63'd0, arready}, 64'd0);
            tick();
        end
        r_finish("rstall");
        axi_read("second stalled write", 6'h18, 32'hCAFE_F00D, RESP_OKAY);

        // ---- Same-cycle read and write of one register ----
        araddr = 6'h14; arvalid = 1'b1;
        rd_q.push_back({RESP_OKAY, 32'h1234_5678});
        wr_start(6'h14, 32'h0BAD_BEEF, 4'hF, RESP_OKAY);
        arvalid = 1'b0;
        b_finish();
        r_finish("same-cycle pre-write");
        axi_read("same-cycle post-write", 6'h14, 32'h0BAD_BEEF, RESP_OKAY);

        // ---- Reset mid-transaction discards B and pending commit ----
        kern_busy = 1'b1;
        axi_write(6'h00, 32'h1, 4'hF, RESP_OKAY);
        axi_read("status before reset", 6'h04, 32'h3, RESP_OKAY);
        wr_start(6'h0C, 32'h7777_7777, 4'hF, RESP_OKAY);
        chk("bvalid before reset", {63'd0, bvalid}, 64'd1);
        rst = 1'b1;
        tick();
        chk("bvalid dropped by reset", {63'd0, bvalid}, 64'd0);
        bresp_q.delete();
        rst = 1'b0;
        kern_busy = 1'b0;
        tick();
        tick();
        tick();
        chk("no pulse after reset", pulse_cnt, 64'd2);
        chk("active cleared", coeff_o[63:0], 64'd0);
        axi_read("status after mid reset", 6'h04, 32'h0, RESP_OKAY);
        axi_read("shadow cleared", 6'h0C, 32'h0, RESP_OKAY);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
